// File: rtl/icache_refill_ctrl_if.sv
// Bundle of requester, IFILL, invalidation and array-write signals for the
// instruction-cache refill controller. The controller uses the slave view.
interface icache_refill_ctrl_if #(
    parameter int unsigned PADDR_W  = 40,
    parameter int unsigned LINE_W   = 512,
    parameter int unsigned OFFSET_W = 6,
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned WAY_W    = 2,
    parameter int unsigned TAG_W    = PADDR_W - OFFSET_W - IDX_W
);
    logic                      dmd_valid_i;
    logic [PADDR_W-1:0]        dmd_paddr_i;
    logic [WAY_W-1:0]          dmd_way_i;
    logic                      dmd_ready_o;
    logic                      pf_valid_i;
    logic [PADDR_W-1:0]        pf_paddr_i;
    logic [WAY_W-1:0]          pf_way_i;
    logic                      pf_ready_o;
    logic                      kill_i;
    logic                      ifill_req_valid_o;
    logic [WAY_W-1:0]          ifill_req_way_o;
    logic [PADDR_W-1:0]        ifill_req_paddr_o;
    logic                      ifill_ack_i;
    logic                      ifill_valid_i;
    logic [LINE_W-1:0]         ifill_data_i;
    logic                      inv_valid_i;
    logic [IDX_W+OFFSET_W-1:0] inv_paddr_i;
    logic                      wr_valid_o;
    logic [WAY_W-1:0]          wr_way_o;
    logic [IDX_W-1:0]          wr_idx_o;
    logic [TAG_W-1:0]          wr_tag_o;
    logic [LINE_W-1:0]         wr_data_o;
    logic                      wr_src_o;
    logic                      inv_valid_o;
    logic [IDX_W-1:0]          inv_idx_o;
    logic                      busy_o;

    modport slave (
        input  dmd_valid_i, dmd_paddr_i, dmd_way_i,
        output dmd_ready_o,
        input  pf_valid_i, pf_paddr_i, pf_way_i,
        output pf_ready_o,
        input  kill_i,
        output ifill_req_valid_o, ifill_req_way_o, ifill_req_paddr_o,
        input  ifill_ack_i, ifill_valid_i, ifill_data_i,
        input  inv_valid_i, inv_paddr_i,
        output wr_valid_o, wr_way_o, wr_idx_o, wr_tag_o, wr_data_o, wr_src_o,
        output inv_valid_o, inv_idx_o, busy_o
    );

    modport master (
        output dmd_valid_i, dmd_paddr_i, dmd_way_i,
        input  dmd_ready_o,
        output pf_valid_i, pf_paddr_i, pf_way_i,
        input  pf_ready_o,
        output kill_i,
        input  ifill_req_valid_o, ifill_req_way_o, ifill_req_paddr_o,
        output ifill_ack_i, ifill_valid_i, ifill_data_i,
        output inv_valid_i, inv_paddr_i,
        input  wr_valid_o, wr_way_o, wr_idx_o, wr_tag_o, wr_data_o, wr_src_o,
        input  inv_valid_o, inv_idx_o, busy_o
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill sequencer: demand/prefetch arbitration, one
// outstanding IFILL transaction, kill/flush and L2 invalidation race handling.
module icache_refill_ctrl #(
    parameter int unsigned PADDR_W  = 40,
    parameter int unsigned LINE_W   = 512,
    parameter int unsigned OFFSET_W = 6,
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned WAY_W    = 2
) (
    input logic                clk_i,
    input logic                rstn_i,
    icache_refill_ctrl_if.slave bus
);
    localparam int unsigned TAG_W  = PADDR_W - OFFSET_W - IDX_W;
    localparam int unsigned LINE_A = PADDR_W - OFFSET_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [LINE_A-1:0]   line_q;
    logic [WAY_W-1:0]    way_q;
    logic                src_q;
    logic [LINE_W-1:0]   data_q;
    logic                killed_q;
    logic                poison_q;
    logic                inv_valid_q;
    logic [IDX_W-1:0]    inv_idx_q;

    logic                accept_dmd;
    logic                accept_pf;
    logic                capture;
    logic                inv_hit;
    logic [IDX_W-1:0]    fill_idx;
    logic [IDX_W-1:0]    inv_in_idx;
    logic                unused_offset_bits;

    assign fill_idx   = line_q[IDX_W-1:0];
    assign inv_in_idx = bus.inv_paddr_i[OFFSET_W +: IDX_W];
    assign inv_hit    = bus.inv_valid_i && (inv_in_idx == fill_idx);
    assign unused_offset_bits = ^{bus.dmd_paddr_i[OFFSET_W-1:0],
                                  bus.pf_paddr_i[OFFSET_W-1:0],
                                  bus.inv_paddr_i[OFFSET_W-1:0]};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            line_q      <= '0;
            way_q       <= '0;
            src_q       <= 1'b0;
            data_q      <= '0;
            killed_q    <= 1'b0;
            poison_q    <= 1'b0;
            inv_valid_q <= 1'b0;
            inv_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            inv_valid_q <= bus.inv_valid_i;
            inv_idx_q   <= inv_in_idx;
            if (accept_dmd) begin
                line_q <= bus.dmd_paddr_i[PADDR_W-1:OFFSET_W];
                way_q  <= bus.dmd_way_i;
                src_q  <= 1'b0;
            end else if (accept_pf) begin
                line_q <= bus.pf_paddr_i[PADDR_W-1:OFFSET_W];
                way_q  <= bus.pf_way_i;
                src_q  <= 1'b1;
            end
            if (capture) begin
                data_q <= bus.ifill_data_i;
            end
            if (state_d == S_IDLE) begin
                killed_q <= 1'b0;
                poison_q <= 1'b0;
            end else begin
                if (state_q == S_REQ && bus.kill_i) begin
                    killed_q <= 1'b1;
                end
                if ((state_q == S_REQ || state_q == S_WAIT) && inv_hit) begin
                    poison_q <= 1'b1;
                end
            end
        end
    end

    // A kill coinciding with the response returns straight to IDLE: the
    // response has already been consumed, so draining would wait forever.
    always_comb begin
        state_d    = state_q;
        accept_dmd = 1'b0;
        accept_pf  = 1'b0;
        capture    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.dmd_valid_i) begin
                    accept_dmd = 1'b1;
                    state_d    = S_REQ;
                end else if (bus.pf_valid_i) begin
                    accept_pf = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.ifill_ack_i) begin
                    if (killed_q || bus.kill_i) begin
                        state_d = bus.ifill_valid_i ? S_IDLE : S_DRAIN;
                    end else if (bus.ifill_valid_i) begin
                        capture = 1'b1;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.kill_i) begin
                    state_d = bus.ifill_valid_i ? S_IDLE : S_DRAIN;
                end else if (bus.ifill_valid_i) begin
                    capture = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (bus.ifill_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.dmd_ready_o       = (state_q == S_IDLE);
    assign bus.pf_ready_o        = (state_q == S_IDLE) && !bus.dmd_valid_i;
    assign bus.busy_o            = (state_q != S_IDLE);
    assign bus.ifill_req_valid_o = (state_q == S_REQ);
    assign bus.ifill_req_way_o   = way_q;
    assign bus.ifill_req_paddr_o = {line_q, {OFFSET_W{1'b0}}};
    assign bus.wr_valid_o        = (state_q == S_WRITE) && !bus.kill_i && !poison_q && !inv_hit;
    assign bus.wr_way_o          = way_q;
    assign bus.wr_idx_o          = fill_idx;
    assign bus.wr_tag_o          = line_q[LINE_A-1 -: TAG_W];
    assign bus.wr_data_o         = data_q;
    assign bus.wr_src_o          = src_q;
    assign bus.inv_valid_o       = inv_valid_q;
    assign bus.inv_idx_o         = inv_idx_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed vector table, hand sequences for
// prefetch/reset corners, and random traffic against a transaction-level model.
module tb_icache_refill_ctrl;
    logic clk;
    logic rstn;
    int   n_pass;
    int   n_total;

    icache_refill_ctrl_if bus ();

    icache_refill_ctrl #(
        .PADDR_W  (40),
        .LINE_W   (512),
        .OFFSET_W (6),
        .IDX_W    (6),
        .WAY_W    (2)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [39:0] DMD_ADDR = 40'h00_8000_1234;
    localparam logic [39:0] PF_ADDR  = 40'h12_3456_7FD5;

    typedef struct {
        bit          dmd, pf, kill, ack, fv, inv;
        logic [11:0] inv_addr;
        bit          busy, dr, pr, reqv, wr, invo, src;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit dmd, bit pf, bit kill, bit ack, bit fv, bit inv,
                                logic [11:0] ia, bit busy, bit dr, bit pr, bit reqv,
                                bit wr, bit invo, bit src);
        vec_t v;
        v.dmd = dmd; v.pf = pf; v.kill = kill; v.ack = ack; v.fv = fv; v.inv = inv;
        v.inv_addr = ia; v.busy = busy; v.dr = dr; v.pr = pr; v.reqv = reqv;
        v.wr = wr; v.invo = invo; v.src = src;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.dmd_valid_i = 1'b0; bus.pf_valid_i = 1'b0; bus.kill_i = 1'b0;
        bus.ifill_ack_i = 1'b0; bus.ifill_valid_i = 1'b0; bus.inv_valid_i = 1'b0;
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // Reference model state: one fill record plus registered invalidation echo.
    bit          m_active, m_acked, m_killed, m_poison, m_wpend, m_src;
    logic [39:0] m_paddr;
    logic [1:0]  m_way;
    logic [511:0] m_data;
    bit          m_inv_v;
    logic [5:0]  m_inv_idx;

    initial begin
        logic [511:0] d_tbl, d_pf, d_rst;
        logic [11:0]  prev_ia;
        logic [63:0]  r;
        logic [39:0]  m_idx40;
        bit           e_busy, e_reqv, e_wr, hit, resp;

        n_pass = 0; n_total = 0;
        rstn = 1'b0;
        idle_inputs();
        bus.dmd_paddr_i = DMD_ADDR; bus.dmd_way_i = 2'd2;
        bus.pf_paddr_i  = PF_ADDR;  bus.pf_way_i  = 2'd1;
        bus.inv_paddr_i = '0;
        d_tbl = rand_line(); d_pf = rand_line(); d_rst = rand_line();
        bus.ifill_data_i = d_tbl;

        // Reset state
        #2;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_dmd_ready", bus.dmd_ready_o, 1);
        chk("rst_pf_ready", bus.pf_ready_o, 1);
        chk("rst_req_valid", bus.ifill_req_valid_o, 0);
        chk("rst_wr_valid", bus.wr_valid_o, 0);
        chk("rst_inv_valid", bus.inv_valid_o, 0);
        bus.dmd_valid_i = 1'b1;
        #1;
        chk("rst_pf_ready_dmd", bus.pf_ready_o, 0);
        bus.dmd_valid_i = 1'b0;
        @(negedge clk); rstn = 1'b1;

        // dmd pf kill ack fv inv ia | busy dr pr reqv wr invo src
        add(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);
        add(0,0,0,0,0,0,0, 1,0,0,1,0,0,0);
        add(0,0,0,0,0,0,0, 1,0,0,1,0,0,0);
        add(0,0,0,1,0,0,0, 1,0,0,1,0,0,0);
        add(0,0,0,0,0,0,0, 1,0,0,0,0,0,0);
        add(0,0,0,0,1,0,0, 1,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0, 1,0,0,0,1,0,0);
        add(1,1,0,0,0,0,0, 0,1,0,0,0,0,0);
        add(0,1,0,1,1,0,0, 1,0,0,1,0,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,0,1,0,0);
        add(0,1,0,0,0,0,0, 0,1,1,0,0,0,0);
        add(0,0,0,1,0,0,0, 1,0,0,1,0,0,1);
        add(0,0,1,0,0,0,0, 1,0,0,0,0,0,1);
        add(0,0,0,0,0,0,0, 1,0,0,0,0,0,1);
        add(0,0,0,0,0,0,0, 1,0,0,0,0,0,1);
        add(0,0,0,0,0,0,0, 1,0,0,0,0,0,1);
        add(0,0,0,0,1,0,0, 1,0,0,0,0,0,1);
        add(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);
        add(0,0,0,1,0,0,0, 1,0,0,1,0,0,0);
        add(0,0,0,0,0,1,12'h200, 1,0,0,0,0,0,0);
        add(0,0,0,0,1,0,0, 1,0,0,0,0,1,0);
        add(0,0,0,0,0,0,0, 1,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);
        add(0,0,0,1,0,0,0, 1,0,0,1,0,0,0);
        add(0,0,0,0,0,1,12'h240, 1,0,0,0,0,0,0);
        add(0,0,0,0,1,0,0, 1,0,0,0,0,1,0);
        add(0,0,0,0,0,0,0, 1,0,0,0,1,0,0);
        add(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);
        add(0,0,0,0,1,0,0, 1,0,0,1,0,0,0);
        add(0,0,0,1,0,0,0, 1,0,0,1,0,0,0);
        add(0,0,0,0,0,0,0, 1,0,0,0,0,0,0);
        add(0,0,0,0,1,0,0, 1,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0, 1,0,0,0,1,0,0);
        add(0,0,0,0,0,0,0, 0,1,1,0,0,0,0);
        add(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);
        add(0,0,0,1,1,0,0, 1,0,0,1,0,0,0);
        add(0,0,1,0,0,0,0, 1,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);
        add(0,0,0,1,1,0,0, 1,0,0,1,0,0,0);
        add(0,0,0,0,0,1,12'h200, 1,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0, 0,1,1,0,0,1,0);

        prev_ia = '0;
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.dmd_valid_i = vecs[i].dmd; bus.pf_valid_i = vecs[i].pf;
            bus.kill_i = vecs[i].kill; bus.ifill_ack_i = vecs[i].ack;
            bus.ifill_valid_i = vecs[i].fv; bus.inv_valid_i = vecs[i].inv;
            bus.inv_paddr_i = vecs[i].inv_addr;
            #1;
            chk($sformatf("v%0d_busy", i), bus.busy_o, vecs[i].busy);
            chk($sformatf("v%0d_dmd_ready", i), bus.dmd_ready_o, vecs[i].dr);
            chk($sformatf("v%0d_pf_ready", i), bus.pf_ready_o, vecs[i].pr);
            chk($sformatf("v%0d_req_valid", i), bus.ifill_req_valid_o, vecs[i].reqv);
            chk($sformatf("v%0d_wr_valid", i), bus.wr_valid_o, vecs[i].wr);
            chk($sformatf("v%0d_inv_valid", i), bus.inv_valid_o, vecs[i].invo);
            if (vecs[i].invo)
                chk($sformatf("v%0d_inv_idx", i), bus.inv_idx_o, prev_ia[11:6]);
            if (vecs[i].reqv) begin
                chk($sformatf("v%0d_req_paddr", i), bus.ifill_req_paddr_o,
                    vecs[i].src ? (PF_ADDR & ~40'h3F) : 40'h00_8000_1200);
                chk($sformatf("v%0d_req_way", i), bus.ifill_req_way_o, vecs[i].src ? 1 : 2);
            end
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_wr_idx", i), bus.wr_idx_o, 6'h08);
                chk($sformatf("v%0d_wr_tag", i), bus.wr_tag_o, 28'h0080001);
                chk($sformatf("v%0d_wr_way", i), bus.wr_way_o, 2);
                chk($sformatf("v%0d_wr_src", i), bus.wr_src_o, 0);
                chk($sformatf("v%0d_wr_data", i), bus.wr_data_o, d_tbl);
            end
            prev_ia = vecs[i].inv_addr;
        end

        // Prefetch fill completing with combined ack+response
        @(negedge clk); idle_inputs(); bus.pf_valid_i = 1'b1;
        #1; chk("pf_ready", bus.pf_ready_o, 1);
        @(negedge clk); bus.pf_valid_i = 1'b0; bus.ifill_ack_i = 1'b1;
        bus.ifill_valid_i = 1'b1; bus.ifill_data_i = d_pf;
        #1; chk("pf_req_paddr", bus.ifill_req_paddr_o, 40'h12_3456_7FC0);
        @(negedge clk); idle_inputs();
        #1;
        chk("pf_wr_valid", bus.wr_valid_o, 1);
        chk("pf_wr_src", bus.wr_src_o, 1);
        chk("pf_wr_idx", bus.wr_idx_o, 6'h3F);
        chk("pf_wr_tag", bus.wr_tag_o, 28'h1234567);
        chk("pf_wr_way", bus.wr_way_o, 1);
        chk("pf_wr_data", bus.wr_data_o, d_pf);

        // Reset while waiting for the response, late response afterwards
        @(negedge clk); bus.dmd_valid_i = 1'b1;
        @(negedge clk); bus.dmd_valid_i = 1'b0; bus.ifill_ack_i = 1'b1;
        @(negedge clk); bus.ifill_ack_i = 1'b0;
        #1; chk("wait_busy", bus.busy_o, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy_o, 0);
        chk("mid_rst_req_valid", bus.ifill_req_valid_o, 0);
        chk("mid_rst_req_paddr", bus.ifill_req_paddr_o, 0);
        chk("mid_rst_wr_valid", bus.wr_valid_o, 0);
        chk("mid_rst_wr_data", bus.wr_data_o, 0);
        chk("mid_rst_wr_tag", bus.wr_tag_o, 0);
        chk("mid_rst_dmd_ready", bus.dmd_ready_o, 1);
        @(negedge clk); rstn = 1'b1; bus.ifill_valid_i = 1'b1; bus.ifill_data_i = d_rst;
        #1; chk("late_resp_busy", bus.busy_o, 0);
        @(negedge clk); idle_inputs();
        #1;
        chk("late_resp_wr_valid", bus.wr_valid_o, 0);
        chk("late_resp_busy2", bus.busy_o, 0);

        // Random traffic against the transaction-level model
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        m_active = 0; m_acked = 0; m_killed = 0; m_poison = 0; m_wpend = 0; m_src = 0;
        m_paddr = '0; m_way = '0; m_data = '0; m_inv_v = 0; m_inv_idx = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            r = {$urandom, $urandom};
            bus.dmd_valid_i   = ($urandom_range(9, 0) < 3);
            bus.pf_valid_i    = ($urandom_range(9, 0) < 3);
            bus.kill_i        = ($urandom_range(19, 0) == 0);
            bus.ifill_ack_i   = ($urandom_range(9, 0) < 4);
            bus.ifill_valid_i = ($urandom_range(9, 0) < 2);
            bus.inv_valid_i   = ($urandom_range(19, 0) < 3);
            bus.dmd_paddr_i   = r[39:0];
            bus.pf_paddr_i    = {r[15:0], r[63:40]};
            bus.dmd_way_i     = r[41:40];
            bus.pf_way_i      = r[43:42];
            bus.ifill_data_i  = rand_line();
            m_idx40 = (m_paddr >> 6) & 40'h3F;
            if ($urandom_range(1, 0) == 1) bus.inv_paddr_i = {m_idx40[5:0], r[5:0]};
            else bus.inv_paddr_i = r[57:46];
            #1;
            hit    = bus.inv_valid_i && ({34'd0, bus.inv_paddr_i[11:6]} == m_idx40);
            e_busy = m_active || m_wpend;
            e_reqv = m_active && !m_acked;
            e_wr   = m_wpend && !bus.kill_i && !m_poison && !hit;
            chk("rnd_busy", bus.busy_o, e_busy);
            chk("rnd_dmd_ready", bus.dmd_ready_o, !e_busy);
            chk("rnd_pf_ready", bus.pf_ready_o, !e_busy && !bus.dmd_valid_i);
            chk("rnd_req_valid", bus.ifill_req_valid_o, e_reqv);
            chk("rnd_wr_valid", bus.wr_valid_o, e_wr);
            chk("rnd_inv_valid", bus.inv_valid_o, m_inv_v);
            if (m_inv_v) chk("rnd_inv_idx", bus.inv_idx_o, m_inv_idx);
            if (e_reqv) begin
                chk("rnd_req_paddr", bus.ifill_req_paddr_o, m_paddr & ~40'h3F);
                chk("rnd_req_way", bus.ifill_req_way_o, m_way);
            end
            if (e_wr) begin
                chk("rnd_wr_idx", bus.wr_idx_o, m_idx40);
                chk("rnd_wr_tag", bus.wr_tag_o, m_paddr >> 12);
                chk("rnd_wr_way", bus.wr_way_o, m_way);
                chk("rnd_wr_src", bus.wr_src_o, m_src);
                chk("rnd_wr_data", bus.wr_data_o, m_data);
            end
            // Advance the model across the upcoming clock edge
            if (m_wpend) begin
                m_wpend = 0;
            end else if (!m_active) begin
                if (bus.dmd_valid_i || bus.pf_valid_i) begin
                    m_active = 1; m_acked = 0; m_killed = 0; m_poison = 0;
                    m_src   = !bus.dmd_valid_i;
                    m_paddr = bus.dmd_valid_i ? bus.dmd_paddr_i : bus.pf_paddr_i;
                    m_way   = bus.dmd_valid_i ? bus.dmd_way_i : bus.pf_way_i;
                end
            end else begin
                resp = 0;
                if (hit) m_poison = 1;
                if (bus.kill_i) m_killed = 1;
                if (!m_acked) begin
                    if (bus.ifill_ack_i) begin
                        m_acked = 1;
                        resp = bus.ifill_valid_i;
                    end
                end else begin
                    resp = bus.ifill_valid_i;
                end
                if (resp) begin
                    m_active = 0;
                    if (!m_killed) begin
                        m_wpend = 1;
                        m_data  = bus.ifill_data_i;
                    end
                end
            end
            m_inv_v   = bus.inv_valid_i;
            m_inv_idx = bus.inv_paddr_i[11:6];
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Sequences instruction-cache line refills over the shared IFILL port.
- Arbitrates between two requesters: demand misses from the fetch controller and next-line prefetches.
- One fill outstanding at a time. Issues the IFILL request, holds it until ack, and captures the full-line response. Emits a single registered array-write command (way, index, tag, data).
- Forwards L2 invalidations to the arrays and handles kill/flush and invalidation races against the in-flight fill.

Parameters:
PADDR_W, 40, physical address width
LINE_W, 512, cache line width in bits
OFFSET_W, 6, line offset bits (log2 of LINE_W/8)
IDX_W, 6, set index bits (16 KB, 4-way, 64 B line)
WAY_W, 2, way select bits
TAG_W, PADDR_W-OFFSET_W-IDX_W (28), derived tag width

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
dmd_valid_i  in  1  demand refill request
dmd_paddr_i  in  PADDR_W  demand miss address
dmd_way_i  in  WAY_W  victim way for demand
dmd_ready_o  out  1  demand accepted when valid&ready
pf_valid_i  in  1  prefetch refill request
pf_paddr_i  in  PADDR_W  prefetch address
pf_way_i  in  WAY_W  victim way for prefetch
pf_ready_o  out  1  prefetch accepted when valid&ready
kill_i  in  1  flush: abandon current fill
ifill_req_valid_o  out  1  IFILL request valid
ifill_req_way_o  out  WAY_W  way to replace
ifill_req_paddr_o  out  PADDR_W  line-aligned physical address
ifill_ack_i  in  1  IFILL request accepted
ifill_valid_i  in  1  full-line response valid
ifill_data_i  in  LINE_W  response line
inv_valid_i  in  1  invalidation from L2
inv_paddr_i  in  IDX_W+OFFSET_W  address to invalidate
wr_valid_o  out  1  write line into arrays, set valid bit
wr_way_o  out  WAY_W  target way
wr_idx_o  out  IDX_W  target set
wr_tag_o  out  TAG_W  tag to store
wr_data_o  out  LINE_W  line data
wr_src_o  out  1  0=demand, 1=prefetch
inv_valid_o  out  1  invalidate set in all ways
inv_idx_o  out  IDX_W  set to invalidate
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. All outputs 0 except dmd_ready_o=1 and pf_ready_o=!dmd_valid_i. Internal kill/poison flags cleared. Reset mid-fill drops the fill silently.
- Ready signals are combinational: dmd_ready_o = (state==IDLE); pf_ready_o = (state==IDLE) & !dmd_valid_i. Demand has strict priority; no preemption of an in-flight prefetch.
- Accept at cycle T:
  - Latch paddr, way and source.
  - ifill_req_valid_o=1 at T+1, with ifill_req_paddr_o[OFFSET_W-1:0]=0.
  - Go to REQ.
- REQ:
  - Request fields held stable until ifill_ack_i; never retracted.
  - Ack alone -> WAIT.
  - Ack and ifill_valid_i in the same cycle -> WRITE, data captured.
  - ifill_valid_i without a prior or concurrent ack is ignored.
- WAIT: on ifill_valid_i, capture data into the wr_data register -> WRITE.
- WRITE (one cycle):
  - wr_valid_o = !kill_i & !poison & !(inv_valid_i & inv index==fill index).
  - wr_tag_o = paddr[PADDR_W-1 -: TAG_W].
  - wr_idx_o = paddr[OFFSET_W +: IDX_W].
  - Then -> IDLE.
- Latency: response cycle R -> wr_valid_o at R+1 -> ready again at R+2.
- Kill:
  - In IDLE: no effect.
  - In REQ: set the killed flag. After ack go to DRAIN (or to IDLE if ack and valid arrive together).
  - In WAIT: -> DRAIN.
  - DRAIN waits for ifill_valid_i, discards the data, -> IDLE with no write.
  - kill_i is not retained once IDLE is reached.
- Invalidation:
  - inv_valid_o/inv_idx_o are registered copies of inv_valid_i/inv_paddr_i[OFFSET_W +: IDX_W], one-cycle latency, in every state including DRAIN.
  - If inv index equals the in-flight fill index while in REQ or WAIT, set poison. The fill completes but wr_valid_o stays 0.
- Poison and killed flags clear on return to IDLE.

Test Plan:
- Demand at paddr 0x00_8000_1234, way 2 -> ifill_req_paddr_o=0x00_8000_1200, way 2, held 3 cycles until ack. Response data D -> next cycle wr_valid_o=1, idx=0x08, tag=0x0080001, data=D, src=0.
- dmd_valid_i and pf_valid_i both high in IDLE -> demand accepted, pf_ready_o=0. Prefetch accepted the cycle after the demand write completes (R+2), src=1.
- kill_i in WAIT, response arrives 4 cycles later -> no wr_valid_o; dmd_ready_o=1 the cycle after the response.
- Fill at idx 0x08 in WAIT, inv_valid_i with inv_paddr_i=0x200 -> inv_valid_o/idx 0x08 next cycle; response produces no write. Same test with inv_paddr_i=0x240 (idx 0x09) -> write occurs.
- ifill_ack_i and ifill_valid_i in the same cycle -> wr_valid_o the next cycle. A stray ifill_valid_i in REQ before ack -> ignored, no write.
- rstn_i low during WAIT -> all outputs 0, busy_o=0. A late response after reset release -> no write.
